// File: rtl/stream_block_checker.sv
// Checks a received byte stream against a programmable expected block repeated NUM_BLOCKS times.
// Reports liveness, pass/fail, a saturating mismatch count and the index of the first mismatch.
module stream_block_checker #(
    parameter int unsigned            DATA_W      = 8,
    parameter int unsigned            BLOCK_BYTES = 16,
    parameter int unsigned            NUM_BLOCKS  = 4,
    parameter logic [NUM_BLOCKS-1:0]  SKIP_MASK   = NUM_BLOCKS'(4'b0010),
    parameter int unsigned            ERR_W       = 8,
    parameter int unsigned            AW          = $clog2(BLOCK_BYTES),
    parameter int unsigned            IW          = $clog2(NUM_BLOCKS * BLOCK_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              exp_we,
    input  logic [AW-1:0]     exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    output logic              busy,
    output logic              done,
    output logic              alive,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [IW-1:0]     first_err_idx,
    output logic              overrun
);

    // Block counter keeps at least one bit so a single-block configuration still elaborates.
    localparam int unsigned BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state;
    logic [AW-1:0]     byte_idx;
    logic [BW-1:0]     block_idx;
    logic [DATA_W-1:0] exp_mem [BLOCK_BYTES];

    logic              block_end;
    logic              last_word;
    logic              skip_block;
    logic              word_match;
    logic              err_sat;
    logic [AW+BW-1:0]  stream_idx;

    always_comb begin
        block_end  = (byte_idx == AW'(BLOCK_BYTES - 1));
        last_word  = block_end && (block_idx == BW'(NUM_BLOCKS - 1));
        skip_block = SKIP_MASK[block_idx];
        // Table read is combinational from the register array, so a same-cycle write is not seen.
        word_match = (rd_data == exp_mem[byte_idx]);
        err_sat    = &err_count;
        stream_idx = {block_idx, byte_idx};
    end

    always_ff @(posedge clk) begin
        if (exp_we) begin
            exp_mem[exp_addr] <= exp_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= StIdle;
            byte_idx        <= '0;
            block_idx       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            alive           <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            overrun         <= 1'b0;
        end else if (start) begin
            // Restart from any state; a coincident rd_valid word is dropped.
            state           <= StRun;
            byte_idx        <= '0;
            block_idx       <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            alive           <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            overrun         <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                end
                StRun: begin
                    if (rd_valid) begin
                        alive    <= 1'b1;
                        byte_idx <= byte_idx + AW'(1);
                        if (block_end) begin
                            block_idx <= block_idx + BW'(1);
                        end
                        if (!skip_block) begin
                            if (word_match) begin
                                if (err_count == '0) begin
                                    pass <= 1'b1;
                                end
                            end else begin
                                pass <= 1'b0;
                                if (!err_sat) begin
                                    err_count <= err_count + ERR_W'(1);
                                end
                                if (!first_err_valid) begin
                                    first_err_valid <= 1'b1;
                                    first_err_idx   <= stream_idx[IW-1:0];
                                end
                            end
                        end
                        if (last_word) begin
                            state     <= StDone;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            block_idx <= '0;
                        end
                    end
                end
                StDone: begin
                    if (rd_valid) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
